// File: rtl/sram_port_arbiter_pkg.sv
// Shared definitions for the SRAM port arbiter.
//   state_e        : FSM state encoding (3 bits)
//   NOP_INST_DEF   : instruction handed to IF when MEM owns the port
//   IO_BASE_DEF    : first address that belongs to IO space, not SRAM
//   RAM_AW_DEF     : default SRAM address width
//   WR_PULSE_DEF   : default number of cycles we_n is held low
package sram_port_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_I = 3'd1,
    ST_RD_D = 3'd2,
    ST_WR_S = 3'd3,
    ST_WR_P = 3'd4,
    ST_WR_H = 3'd5
  } state_e;

  localparam logic [15:0] NOP_INST_DEF = 16'h0800;
  localparam logic [15:0] IO_BASE_DEF  = 16'hBF00;
  localparam int unsigned RAM_AW_DEF   = 18;
  localparam int unsigned WR_PULSE_DEF = 1;

  // True for the three phases of a store (setup, pulse, hold).
  function automatic logic is_wr_state(input state_e s);
    return (s == ST_WR_S) || (s == ST_WR_P) || (s == ST_WR_H);
  endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// Arbitrates the single 16-bit SRAM port between instruction fetch (IF) and
// the MEM stage, and sequences the SRAM read/write strobes.
//
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   if_req/if_addr           : fetch request (level) and address
//   if_inst/if_valid         : fetched instruction (registered) and 1-cycle valid
//   mem_rd/mem_wr            : load / store requests (level)
//   mem_addr/mem_wdata       : load/store address and store data
//   mem_rdata/mem_done       : load data (registered) and 1-cycle completion
//   mem_conflict             : MEM holds or wants the SRAM; IF must stall / take a nop
//   io_sel                   : MEM access targets IO space; not routed to SRAM
//   ram_addr/ram_dout/ram_din: SRAM address, write data, read data
//   ram_doe                  : enable for the external tristate driving ram_dout
//   ram_ce_n/oe_n/we_n       : SRAM strobes, active-low
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter logic [15:0] IO_BASE  = IO_BASE_DEF,
  parameter int unsigned RAM_AW   = RAM_AW_DEF,
  parameter int unsigned WR_PULSE = WR_PULSE_DEF,
  parameter logic [15:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [15:0]       if_addr,
  output logic [15:0]       if_inst,
  output logic              if_valid,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [15:0]       mem_addr,
  input  logic [15:0]       mem_wdata,
  output logic [15:0]       mem_rdata,
  output logic              mem_done,
  output logic              mem_conflict,
  output logic              io_sel,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [15:0]       ram_dout,
  input  logic [15:0]       ram_din,
  output logic              ram_doe,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] if_inst_q, if_inst_d;
  logic [15:0] mem_rdata_q, mem_rdata_d;
  logic        if_valid_q, if_valid_d;
  logic        mem_done_q, mem_done_d;

  logic mem_in_ram;
  logic mem_ram;

  // IO-space accesses are handled elsewhere; the arbiter never sees them.
  assign mem_in_ram   = (mem_addr < IO_BASE);
  assign mem_ram      = (mem_rd | mem_wr) & mem_in_ram;
  assign io_sel       = (mem_rd | mem_wr) & ~mem_in_ram;
  assign mem_conflict = mem_ram | (state_q == ST_RD_D) | is_wr_state(state_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      if_inst_q   <= NOP_INST;
      mem_rdata_q <= '0;
      if_valid_q  <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      if_valid_q  <= if_valid_d;
      mem_done_q  <= mem_done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    if_valid_d  = 1'b0;
    mem_done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Store beats load beats fetch; the op is implied by the next state,
        // and address/data are frozen here for the whole transaction.
        if (mem_wr && mem_in_ram) begin
          state_d = ST_WR_S;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
        end else if (mem_rd && mem_in_ram) begin
          state_d = ST_RD_D;
          addr_d  = mem_addr;
        end else if (if_req) begin
          state_d = ST_RD_I;
          addr_d  = if_addr;
        end
      end
      ST_RD_I: begin
        if_inst_d  = ram_din;
        if_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      ST_RD_D: begin
        mem_rdata_d = ram_din;
        mem_done_d  = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_WR_S: begin
        // Counter holds the remaining pulse cycles after the current one.
        cnt_d   = 3'(WR_PULSE - 1);
        state_d = ST_WR_P;
      end
      ST_WR_P: begin
        if (cnt_q == 3'd0) begin
          state_d = ST_WR_H;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_WR_H: begin
        mem_done_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an asynchronous
  // reset releases the bus immediately.
  assign ram_ce_n = (state_q == ST_IDLE) || !((state_q == ST_RD_I) ||
                    (state_q == ST_RD_D) || is_wr_state(state_q));
  assign ram_oe_n = !((state_q == ST_RD_I) || (state_q == ST_RD_D));
  assign ram_we_n = (state_q != ST_WR_P);
  assign ram_doe  = is_wr_state(state_q);

  assign ram_addr  = {{(RAM_AW-16){1'b0}}, addr_q};
  assign ram_dout  = wdata_q;
  assign if_inst   = if_inst_q;
  assign if_valid  = if_valid_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter. Two instances share the request
// inputs: u_dut1 (WR_PULSE=1) and u_dut3 (WR_PULSE=3), each with its own
// small SRAM model.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic        mem_rd, mem_wr;
  logic [15:0] mem_addr, mem_wdata;

  logic [15:0] if_inst1, mem_rdata1, ram_dout1, ram_din1;
  logic        if_valid1, mem_done1, mem_conflict1, io_sel1;
  logic [17:0] ram_addr1;
  logic        ram_doe1, ram_ce_n1, ram_oe_n1, ram_we_n1;

  logic [15:0] if_inst3, mem_rdata3, ram_dout3, ram_din3;
  logic        if_valid3, mem_done3, mem_conflict3, io_sel3;
  logic [17:0] ram_addr3;
  logic        ram_doe3, ram_ce_n3, ram_oe_n3, ram_we_n3;

  logic [15:0] sram1 [0:255];
  logic [15:0] sram3 [0:255];

  always #5 clk = ~clk;

  sram_port_arbiter #(.WR_PULSE(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst1), .if_valid(if_valid1),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata1), .mem_done(mem_done1), .mem_conflict(mem_conflict1),
    .io_sel(io_sel1), .ram_addr(ram_addr1), .ram_dout(ram_dout1), .ram_din(ram_din1),
    .ram_doe(ram_doe1), .ram_ce_n(ram_ce_n1), .ram_oe_n(ram_oe_n1), .ram_we_n(ram_we_n1)
  );

  sram_port_arbiter #(.WR_PULSE(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_inst(if_inst3), .if_valid(if_valid3),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata3), .mem_done(mem_done3), .mem_conflict(mem_conflict3),
    .io_sel(io_sel3), .ram_addr(ram_addr3), .ram_dout(ram_dout3), .ram_din(ram_din3),
    .ram_doe(ram_doe3), .ram_ce_n(ram_ce_n3), .ram_oe_n(ram_oe_n3), .ram_we_n(ram_we_n3)
  );

  // SRAM models: preloaded while reset is low, written when ce_n & we_n are low.
  assign ram_din1 = sram1[ram_addr1[7:0]];
  assign ram_din3 = sram3[ram_addr3[7:0]];

  always @(posedge clk) begin
    if (!rst) begin
      sram1[3] <= 16'h6901; sram1[5] <= 16'h4455; sram1[8] <= 16'h1234;
      sram3[3] <= 16'h6901; sram3[5] <= 16'h4455; sram3[8] <= 16'h1234;
    end else begin
      if (!ram_ce_n1 && !ram_we_n1) sram1[ram_addr1[7:0]] <= ram_dout1;
      if (!ram_ce_n3 && !ram_we_n3) sram3[ram_addr3[7:0]] <= ram_dout3;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Per-cycle statistics, sampled 1 time unit after each rising edge.
  int edge_n, we_lo1, we_lo3, oe_lo1, oe_lo3, doe_n1, doe_n3;
  int done_at1, done_at3, done_cnt1, done_cnt3;
  int overlap = 0;

  task automatic clr;
    edge_n = 0; we_lo1 = 0; we_lo3 = 0; oe_lo1 = 0; oe_lo3 = 0;
    doe_n1 = 0; doe_n3 = 0; done_at1 = 0; done_at3 = 0; done_cnt1 = 0; done_cnt3 = 0;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    edge_n++;
    if (!ram_we_n1) we_lo1++;
    if (!ram_we_n3) we_lo3++;
    if (!ram_oe_n1) oe_lo1++;
    if (!ram_oe_n3) oe_lo3++;
    if (ram_doe1) doe_n1++;
    if (ram_doe3) doe_n3++;
    if (mem_done1) begin done_cnt1++; if (done_at1 == 0) done_at1 = edge_n; end
    if (mem_done3) begin done_cnt3++; if (done_at3 == 0) done_at3 = edge_n; end
    if (!ram_oe_n1 && !ram_we_n1) overlap++;
    if (!ram_oe_n3 && !ram_we_n3) overlap++;
  endtask

  task automatic idle_bus;
    if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; idle_bus();
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    clr();
    repeat (3) tick();

    // Reset state
    chk("rst_ce_n",  ram_ce_n1, 1);
    chk("rst_oe_n",  ram_oe_n1, 1);
    chk("rst_we_n",  ram_we_n1, 1);
    chk("rst_doe",   ram_doe1, 0);
    chk("rst_addr",  ram_addr1, 0);
    chk("rst_dout",  ram_dout1, 0);
    chk("rst_inst",  if_inst1, 16'h0800);
    chk("rst_rdata", mem_rdata1, 0);
    chk("rst_valid", if_valid1, 0);
    chk("rst_done",  mem_done1, 0);
    rst = 1'b1;
    tick();

    // Instruction fetch from address 3
    if_req = 1'b1; if_addr = 16'h0003;
    tick();
    chk("rdi_addr",  ram_addr1, 18'h00003);
    chk("rdi_oe_n",  ram_oe_n1, 0);
    chk("rdi_early", if_valid1, 0);
    tick();
    chk("rdi_inst",  if_inst1, 16'h6901);
    chk("rdi_valid", if_valid1, 1);
    if_req = 1'b0;
    tick();
    chk("rdi_pulse", if_valid1, 0);
    chk("rdi_oe_off", ram_oe_n1, 1);

    // Store to IO space never reaches the SRAM
    mem_wr = 1'b1; mem_addr = 16'hCF00; mem_wdata = 16'hCF00;
    #1;
    chk("io_wr_sel",  io_sel1, 1);
    chk("io_wr_conf", mem_conflict1, 0);
    tick();
    chk("io_wr_ce_n", ram_ce_n1, 1);
    mem_wr = 1'b0;
    tick();

    // Store 0xCF00 to SRAM address 0x00C0, WR_PULSE=1
    mem_wr = 1'b1; mem_addr = 16'h00C0; mem_wdata = 16'hCF00;
    #1;
    chk("wr_conf", mem_conflict1, 1);
    chk("wr_iosel", io_sel1, 0);
    clr();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 0) begin
        chk("wrs_addr", ram_addr1, 18'h000C0);
        chk("wrs_dout", ram_dout1, 16'hCF00);
        chk("wrs_we_n", ram_we_n1, 1);
      end
      if (mem_done1) break;
    end
    mem_wr = 1'b0;
    chk("wr1_we_cycles",  we_lo1, 1);
    chk("wr1_doe_cycles", doe_n1, 3);
    chk("wr1_done_edge",  done_at1, 4);
    chk("wr1_oe_low",     oe_lo1, 0);
    tick();
    chk("wr1_done_pulse", mem_done1, 0);
    repeat (4) tick();

    // Read the stored word back
    mem_rd = 1'b1; mem_addr = 16'h00C0;
    tick();
    chk("rb_oe_n", ram_oe_n1, 0);
    tick();
    chk("rb_done",   mem_done1, 1);
    chk("rb_rdata1", mem_rdata1, 16'hCF00);
    chk("rb_rdata3", mem_rdata3, 16'hCF00);
    mem_rd = 1'b0;
    tick();

    // Simultaneous fetch and load: load first, fetch after one IDLE cycle
    if_req = 1'b1; if_addr = 16'h0005; mem_rd = 1'b1; mem_addr = 16'h0008;
    #1;
    chk("arb_conf", mem_conflict1, 1);
    tick();
    chk("arb_rdd_addr", ram_addr1, 18'h00008);
    tick();
    chk("arb_rdata", mem_rdata1, 16'h1234);
    chk("arb_done",  mem_done1, 1);
    chk("arb_no_if", if_valid1, 0);
    mem_rd = 1'b0;
    #1;
    chk("arb_conf_off", mem_conflict1, 0);
    tick();
    chk("arb_rdi_addr", ram_addr1, 18'h00005);
    chk("arb_rdi_oe",   ram_oe_n1, 0);
    tick();
    chk("arb_if_valid", if_valid1, 1);
    chk("arb_if_inst",  if_inst1, 16'h4455);
    if_req = 1'b0;
    tick();

    // IO-space load alongside fetch: fetch proceeds untouched
    mem_rd = 1'b1; mem_addr = 16'hBF00; if_req = 1'b1; if_addr = 16'h0003;
    #1;
    chk("io_rd_sel",  io_sel1, 1);
    chk("io_rd_conf", mem_conflict1, 0);
    tick();
    chk("io_rdi_addr", ram_addr1, 18'h00003);
    tick();
    chk("io_if_valid", if_valid1, 1);
    chk("io_if_inst",  if_inst1, 16'h6901);
    chk("io_no_done",  mem_done1, 0);
    idle_bus();
    tick();

    // WR_PULSE=3 with load and store both asserted: store wins
    mem_wr = 1'b1; mem_rd = 1'b1; mem_addr = 16'h0010; mem_wdata = 16'hA5A5;
    clr();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_done3) break;
    end
    idle_bus();
    chk("wr3_we_cycles",  we_lo3, 3);
    chk("wr3_oe_low",     oe_lo3, 0);
    chk("wr3_done_edge",  done_at3, 6);
    chk("wr3_doe_cycles", doe_n3, 5);
    repeat (4) tick();
    chk("wr3_mem", sram3[16], 16'hA5A5);

    // Reset asserted in the middle of the write pulse
    mem_wr = 1'b1; mem_addr = 16'h0020; mem_wdata = 16'h1111;
    tick();
    tick();
    chk("rstw_we_low", ram_we_n3, 0);
    rst = 1'b0;
    #1;
    chk("rstw_we_n", ram_we_n3, 1);
    chk("rstw_ce_n", ram_ce_n3, 1);
    chk("rstw_oe_n", ram_oe_n3, 1);
    chk("rstw_doe",  ram_doe3, 0);
    mem_wr = 1'b0;
    clr();
    repeat (3) tick();
    rst = 1'b1;
    repeat (6) tick();
    chk("rstw_no_done3", done_cnt3, 0);
    chk("rstw_no_done1", done_cnt1, 0);

    chk("oe_we_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
